// File: rtl/route_arbiter_if.sv
// Crossbar handshake bundle between the SpaceWire receive channels and the transmit channels.
// The master drives input bytes and output ready; the arbiter is the slave.
interface route_arbiter_if #(
    parameter int unsigned COUNT = 8
);
    logic [COUNT-1:0]   in_valid;
    logic [COUNT*8-1:0] in_data;
    logic [COUNT-1:0]   in_eop;
    logic [COUNT-1:0]   in_ready;
    logic [COUNT-1:0]   out_valid;
    logic [COUNT*8-1:0] out_data;
    logic [COUNT-1:0]   out_eop;
    logic [COUNT-1:0]   out_ready;

    modport master (
        output in_valid, in_data, in_eop, out_ready,
        input  in_ready, out_valid, out_data, out_eop
    );

    modport slave (
        input  in_valid, in_data, in_eop, out_ready,
        output in_ready, out_valid, out_data, out_eop
    );
endinterface

// File: rtl/route_arbiter.sv
// Packet crossbar arbiter: strips the address byte, locks an output per packet, round-robin per output.
// Define ROUTE_DROP_CNT_EN to add the saturating drop_cnt output.
module route_arbiter #(
    parameter int unsigned COUNT = 8
) (
    input  logic           clk,
    input  logic           rst,
    route_arbiter_if.slave bus
`ifdef ROUTE_DROP_CNT_EN
    ,
    output logic [15:0]    drop_cnt
`endif
);
    localparam int unsigned AW = (COUNT > 1) ? $clog2(COUNT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_DROP} state_t;

    state_t           state     [COUNT];
    logic [AW-1:0]    dest      [COUNT];
    logic [COUNT-1:0] busy;
    logic [AW-1:0]    owner     [COUNT];
    logic [AW-1:0]    ptr       [COUNT];

    logic [COUNT-1:0] rdy;
    logic [COUNT-1:0] in_hs;
    logic [COUNT-1:0] grant_vld;
    logic [COUNT-1:0] granted_in;
    logic [AW-1:0]    grant_idx [COUNT];
    logic [AW-1:0]    grant_ptr [COUNT];

    // Input acceptance; in XFER the input follows the locked output's sink.
    always_comb begin
        rdy = '0;
        for (int unsigned i = 0; i < COUNT; i++) begin
            if (!rst) begin
                case (state[i])
                    S_IDLE:  rdy[i] = 1'b1;
                    S_REQ:   rdy[i] = 1'b0;
                    S_XFER:  rdy[i] = bus.out_ready[dest[i]];
                    S_DROP:  rdy[i] = 1'b1;
                    default: rdy[i] = 1'b0;
                endcase
            end
        end
    end

    assign bus.in_ready = rdy;
    assign in_hs        = bus.in_valid & rdy;

    // Round-robin pick per free output: first requester at or after ptr, wrapping.
    always_comb begin
        int unsigned j;
        logic [AW-1:0] jj;
        j          = 0;
        jj         = '0;
        grant_vld  = '0;
        granted_in = '0;
        for (int unsigned p = 0; p < COUNT; p++) begin
            grant_idx[p] = '0;
            grant_ptr[p] = '0;
        end
        for (int unsigned p = 0; p < COUNT; p++) begin
            if (!busy[p]) begin
                for (int unsigned k = 0; k < COUNT; k++) begin
                    j = 32'(ptr[p]) + k;
                    if (j >= COUNT) j = j - COUNT;
                    jj = AW'(j);
                    if (!grant_vld[p] && state[jj] == S_REQ && dest[jj] == AW'(p)) begin
                        grant_vld[p]   = 1'b1;
                        grant_idx[p]   = jj;
                        granted_in[jj] = 1'b1;
                        grant_ptr[p]   = (j == COUNT - 1) ? '0 : AW'(j + 1);
                    end
                end
            end
        end
    end

    // Crossbar: each busy output mirrors its owner's byte lane.
    always_comb begin
        bus.out_valid = '0;
        bus.out_eop   = '0;
        bus.out_data  = '0;
        for (int unsigned p = 0; p < COUNT; p++) begin
            if (!rst && busy[p]) begin
                bus.out_valid[p]        = bus.in_valid[owner[p]];
                bus.out_eop[p]          = bus.in_eop[owner[p]];
                bus.out_data[8*p +: 8]  = bus.in_data[8*32'(owner[p]) +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
            for (int unsigned i = 0; i < COUNT; i++) begin
                state[i] <= S_IDLE;
                dest[i]  <= '0;
                owner[i] <= '0;
                ptr[i]   <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < COUNT; i++) begin
                case (state[i])
                    S_IDLE: begin
                        if (in_hs[i]) begin
                            dest[i] <= bus.in_data[8*i +: AW];
                            if (!bus.in_eop[i]) begin
                                state[i] <= (32'(bus.in_data[8*i +: 8]) < COUNT) ? S_REQ : S_DROP;
                            end
                        end
                    end
                    S_REQ:   if (granted_in[i]) state[i] <= S_XFER;
                    S_XFER:  if (in_hs[i] && bus.in_eop[i]) state[i] <= S_IDLE;
                    S_DROP:  if (in_hs[i] && bus.in_eop[i]) state[i] <= S_IDLE;
                    default: state[i] <= S_IDLE;
                endcase
            end
            for (int unsigned p = 0; p < COUNT; p++) begin
                if (grant_vld[p]) begin
                    busy[p]  <= 1'b1;
                    owner[p] <= grant_idx[p];
                    ptr[p]   <= grant_ptr[p];
                end else if (busy[p] && in_hs[owner[p]] && bus.in_eop[owner[p]]) begin
                    busy[p]  <= 1'b0;
                end
            end
        end
    end

`ifdef ROUTE_DROP_CNT_EN
    localparam int unsigned DW = 16;

    logic [COUNT-1:0] drop_done;
    logic [DW:0]      drop_sum;

    // A drop completes on an EOP handshake in DROP, or a header that carries EOP.
    always_comb begin
        drop_done = '0;
        drop_sum  = {1'b0, drop_cnt};
        for (int unsigned i = 0; i < COUNT; i++) begin
            drop_done[i] = in_hs[i] & bus.in_eop[i] & (state[i] == S_IDLE || state[i] == S_DROP);
            drop_sum     = drop_sum + (DW+1)'(drop_done[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) drop_cnt <= '0;
        else     drop_cnt <= drop_sum[DW] ? '1 : drop_sum[DW-1:0];
    end
`endif

endmodule

// File: tb/tb_route_arbiter.sv
// Self-checking bench for route_arbiter: vector table plus multi-cycle sequences, per-output scoreboard.
module tb_route_arbiter;
    localparam int unsigned COUNT = 8;
    localparam int unsigned AW    = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    route_arbiter_if #(.COUNT(COUNT)) bus ();
`ifdef ROUTE_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    route_arbiter #(.COUNT(COUNT)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus)
`ifdef ROUTE_DROP_CNT_EN
        ,
        .drop_cnt (drop_cnt)
`endif
    );

    typedef struct {
        int         src;
        logic [7:0] hdr;
        int         len;
        logic [7:0] base;
        int         steps;
        int         dest;   // -1 when the packet must be discarded
    } vec_t;

    // Entries: {first/header flag, eop, data}
    logic [9:0]       tx_q  [COUNT][$];
    logic [9:0]       exp_q [COUNT][$];
    int               hdr_cyc   [COUNT];
    int               first_cyc [COUNT];
    logic [COUNT-1:0] ordy;
    int               cyc;
    int               n_assert;
    int               n_fail;
    int               exp_drops;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_drops(input string name);
`ifdef ROUTE_DROP_CNT_EN
        chk(name, 32'(drop_cnt), exp_drops);
`endif
    endtask

    task automatic drive();
        logic [COUNT-1:0]   v;
        logic [COUNT-1:0]   e;
        logic [COUNT*8-1:0] d;
        v = '0;
        e = '0;
        d = '0;
        for (int i = 0; i < COUNT; i++) begin
            if (tx_q[i].size() > 0) begin
                v[i]         = 1'b1;
                e[i]         = tx_q[i][0][8];
                d[8*i +: 8]  = tx_q[i][0][7:0];
            end
        end
        bus.in_valid  = v;
        bus.in_eop    = e;
        bus.in_data   = d;
        bus.out_ready = ordy;
    endtask

    task automatic queue_pkt(input int src, input logic [7:0] hdr, input int len, input logic [7:0] base);
        tx_q[src].push_back({1'b1, (len == 0), hdr});
        for (int k = 0; k < len; k++)
            tx_q[src].push_back({1'b0, (k == len - 1), 8'(base + 8'(k))});
        if (hdr < 8'(COUNT) && len > 0) begin
            for (int k = 0; k < len; k++)
                exp_q[hdr[AW-1:0]].push_back({(k == 0), (k == len - 1), 8'(base + 8'(k))});
        end else begin
            exp_drops++;
        end
    endtask

    // One clock: sample at negedge, score outputs, retire handshaken bytes, drive next inputs.
    task automatic step();
        logic [COUNT-1:0] hs;
        logic [9:0]       ent;
        @(negedge clk);
        hs = bus.in_valid & bus.in_ready;
        for (int p = 0; p < COUNT; p++) begin
            if (exp_q[p].size() == 0) begin
                chk($sformatf("idle_out%0d", p),
                    {22'd0, bus.out_valid[p], bus.out_eop[p], bus.out_data[8*p +: 8]}, 0);
            end else if (bus.out_valid[p] && bus.out_ready[p]) begin
                ent = exp_q[p].pop_front();
                chk($sformatf("out%0d_byte", p), {23'd0, bus.out_eop[p], bus.out_data[8*p +: 8]},
                    {23'd0, ent[8:0]});
                if (ent[9]) first_cyc[p] = cyc;
            end
        end
        for (int i = 0; i < COUNT; i++) begin
            if (hs[i]) begin
                ent = tx_q[i].pop_front();
                if (ent[9]) hdr_cyc[i] = cyc;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
        drive();
    endtask

    function automatic bit all_idle();
        for (int i = 0; i < COUNT; i++)
            if (tx_q[i].size() != 0 || exp_q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic flush();
        for (int i = 0; i < COUNT; i++) begin
            tx_q[i].delete();
            exp_q[i].delete();
        end
    endtask

    task automatic run(input int budget, output int steps);
        steps = 0;
        while (!all_idle() && steps < budget) begin
            step();
            steps++;
        end
        if (!all_idle()) begin
            n_assert++;
            n_fail++;
            $display("FAIL run_timeout: traffic still pending after %0d cycles", budget);
            flush();
            drive();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    vec_t vt [8];
    int   steps;
    int   s2;

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        exp_drops = 0;
        cyc       = 0;
        for (int i = 0; i < COUNT; i++) begin
            hdr_cyc[i]   = 0;
            first_cyc[i] = 0;
        end

        // Reset with traffic presented: nothing may be accepted or emitted.
        rst           = 1'b1;
        ordy          = '1;
        bus.in_valid  = '1;
        bus.in_eop    = '0;
        bus.in_data   = {COUNT{8'h02}};
        bus.out_ready = '1;
        #1;
        chk("rst_pre_in_ready", 32'(bus.in_ready), 0);
        chk("rst_pre_out_valid", 32'(bus.out_valid), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_eop", 32'(bus.out_eop), 0);
        chk("rst_out_data_lo", bus.out_data[31:0], 0);
        chk("rst_out_data_hi", bus.out_data[63:32], 0);
        check_drops("rst_drops");
        rst = 1'b0;
        drive();
        #1;
        chk("idle_in_ready", 32'(bus.in_ready), 32'hFF);

        vt[0] = '{0, 8'h03, 2, 8'hA1, 4, 3};
        vt[1] = '{2, 8'h09, 3, 8'hB0, 4, -1};
        vt[2] = '{7, 8'h00, 1, 8'hC0, 3, 0};
        vt[3] = '{4, 8'hFF, 1, 8'hD0, 2, -1};
        vt[4] = '{5, 8'h06, 0, 8'h00, 1, -1};
        vt[5] = '{3, 8'h0B, 2, 8'hE0, 3, -1};
        vt[6] = '{6, 8'h07, 4, 8'h70, 6, 7};
        vt[7] = '{1, 8'h01, 3, 8'h11, 5, 1};

        for (int v = 0; v < 8; v++) begin
            queue_pkt(vt[v].src, vt[v].hdr, vt[v].len, vt[v].base);
            drive();
            run(50, steps);
            chk($sformatf("vec%0d_cycles", v), steps, vt[v].steps);
            if (vt[v].dest >= 0)
                chk($sformatf("vec%0d_latency", v), first_cyc[vt[v].dest] - hdr_cyc[vt[v].src], 2);
            check_drops($sformatf("vec%0d_drops", v));
        end

        // Inputs 1 and 5 contend for port 2; input 1 re-requests right after its packet.
        queue_pkt(1, 8'h02, 3, 8'h10);
        queue_pkt(5, 8'h02, 2, 8'h50);
        queue_pkt(1, 8'h02, 2, 8'h18);
        drive();
        run(60, steps);
        chk("contend_cycles", steps, 11);

        // Pointer now sits at 2: input 3 wins over input 0, then 0 follows via wrap.
        queue_pkt(3, 8'h02, 2, 8'h60);
        queue_pkt(0, 8'h02, 2, 8'h30);
        drive();
        run(40, steps);
        chk("rr_cycles", steps, 7);

        // Sink on port 4 stalls for 5 cycles mid-packet.
        queue_pkt(2, 8'h04, 6, 8'h40);
        drive();
        for (int k = 0; k < 4; k++) step();
        ordy[4]       = 1'b0;
        bus.out_ready = ordy;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("stall_in_ready", 32'(bus.in_ready[2]), 0);
            chk("stall_out_valid", 32'(bus.out_valid[4]), 1);
            step();
        end
        ordy[4]       = 1'b1;
        bus.out_ready = ordy;
        #1;
        chk("unstall_in_ready", 32'(bus.in_ready[2]), 1);
        run(40, steps);
        chk("stall_tail_cycles", steps, 4);

        // Two independent routes run concurrently at full rate.
        queue_pkt(0, 8'h06, 4, 8'h80);
        queue_pkt(7, 8'h01, 4, 8'h90);
        drive();
        for (int k = 0; k < 3; k++) step();
        #1;
        chk("parallel_valid", {30'd0, bus.out_valid[6], bus.out_valid[1]}, 3);
        run(40, s2);
        chk("parallel_cycles", 3 + s2, 6);
        chk("parallel_lat6", first_cyc[6] - hdr_cyc[0], 2);
        chk("parallel_lat1", first_cyc[1] - hdr_cyc[7], 2);

        // Header-only packets on three inputs in the same cycle.
        queue_pkt(0, 8'h01, 0, 8'h00);
        queue_pkt(1, 8'h02, 0, 8'h00);
        queue_pkt(2, 8'h20, 0, 8'h00);
        drive();
        run(10, steps);
        chk("multidrop_cycles", steps, 1);
        check_drops("multidrop_drops");

        // Reset in the middle of a packet truncates it.
        queue_pkt(0, 8'h03, 6, 8'h20);
        drive();
        for (int k = 0; k < 4; k++) step();
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 0);
        chk("midrst_in_ready", 32'(bus.in_ready), 0);
        chk("midrst_out_eop", 32'(bus.out_eop), 0);
        chk("midrst_out_data", bus.out_data[31:0], 0);
        flush();
        exp_drops = 0;
        drive();
        step();
        step();
        check_drops("midrst_drops");
        rst = 1'b0;
        queue_pkt(6, 8'h03, 2, 8'h66);
        drive();
        run(20, steps);
        chk("post_rst_cycles", steps, 4);
        chk("post_rst_latency", first_cyc[3] - hdr_cyc[6], 2);
        check_drops("post_rst_drops");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/route_arbiter.md
# route_arbiter

Packet-level crossbar arbiter between the receive side and the transmit side of the `COUNT` SpaceWire channels. Each receive channel delivers packets whose first byte is a destination port address. The arbiter strips that byte and locks the addressed output port to the input for the whole packet. It resolves contention per output with round-robin priority and discards packets with an invalid address.

## Interface
- `COUNT`, 8, number of ports; input and output port count are equal.
- `AW`, `$clog2(COUNT)` with a minimum of 1, address/owner width (derived, not overridden).
- `clk` input 1: single clock; all state is updated on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input `COUNT`: byte present on input i.
- `in_data` input `COUNT*8`: input i byte at `[8i+7:8i]`.
- `in_eop` input `COUNT`: byte on input i is the last of its packet.
- `in_ready` output `COUNT`: input i byte accepted this cycle when `in_valid[i]` is also high.
- `out_valid` output `COUNT`: byte present on output p.
- `out_data` output `COUNT*8`: output p byte at `[8p+7:8p]`.
- `out_eop` output `COUNT`: last byte of the packet on output p.
- `out_ready` input `COUNT`: output p sink accepts the byte this cycle.
- `drop_cnt` output 16: present only with `ROUTE_DROP_CNT_EN` (see Configuration).

## Operation
- Per-input FSM:
  - IDLE: `in_ready=1`. A header handshake latches `dest = in_data[i][AW-1:0]` and checks the full byte against `COUNT`:
    - header byte < `COUNT` and `in_eop=0` → REQ.
    - header byte ≥ `COUNT` and `in_eop=0` → DROP.
    - `in_eop=1` on the header → stays IDLE, packet discarded, counted as a drop.
  - REQ: `in_ready=0`; requests output `dest`. On grant → XFER.
  - XFER: `in_ready[i]=out_ready[dest]`. An EOP handshake → IDLE.
  - DROP: `in_ready=1`; bytes are discarded. An EOP handshake → IDLE and the packet is counted as a drop.
- Per-output state: `busy`, `owner[AW-1:0]`, `ptr[AW-1:0]`.
  - When not busy and at least one input in REQ targets p, grant the first requester at or after `ptr`, scanning upward with wrap from `COUNT-1` to 0.
  - On grant: `busy=1`, `owner=j`, `ptr=(j+1) mod COUNT`.
  - Release: `busy=0` on the EOP handshake of the owner.
- Datapath is combinational through the crossbar; no byte is buffered:
  - `out_valid[p]=busy[p] & in_valid[owner]`
  - `out_data[p]=in_data[owner]`
  - `out_eop[p]=in_eop[owner]`
  - The header byte never appears on any output.
- A byte transfers on an output only when `out_valid & out_ready`. That handshake is the same event as the input handshake.
- Outputs that are not busy drive `out_valid=0`, `out_eop=0`, `out_data=8'h00`.

## Timing
- Reset: all inputs go to IDLE, all outputs not busy, `ptr=0`, and `drop_cnt=0` when present.
  - While `rst` is high: `in_ready=0`, `out_valid=0`, `out_eop=0`, `out_data=0`.
- Header handshake in cycle N puts the input in REQ at N+1.
- If the output is free at N+1, the grant registers at the N+1→N+2 edge and the first payload byte can transfer in N+2.
- Payload throughput is one byte per cycle; there is zero added latency per byte.
- EOP handshake in cycle M:
  - The output is free and the input is IDLE at M+1.
  - The input can accept a new header at M+1.
  - Another requester of that output can be granted at the M+1 edge and transfer at M+2.
- Simultaneous requests to one output are resolved by `ptr` only; no input can be starved beyond `COUNT-1` packets.
- Simultaneous requests to different outputs are granted in the same cycle, independently.
- An owner stalling with `in_valid=0` holds the output indefinitely.
- Reset during XFER truncates the packet: no EOP is emitted. Recovery from a truncated packet is the downstream channel's responsibility.

## Configuration
- `ROUTE_DROP_CNT_EN` defined: adds the `drop_cnt[15:0]` output.
  - Increments by 1 for each discarded packet (invalid address or header-only).
  - Saturates at `16'hFFFF`; cleared only by `rst`.
  - If several inputs complete drops in the same cycle, it adds the number of drops, still saturating.
- Not defined: the port and counter are absent; drop behaviour is otherwise identical.

## Test plan
- `COUNT=8`, input 0 sends header 3 then `8'hA1`, `8'hA2` (with EOP), `out_ready=1` → output 3 shows A1 then A2 with EOP. Header to A1 output latency is 2 cycles; no other output is valid.
- Inputs 1 and 5 send header 2 in the same cycle, `ptr[2]=0` → input 1 granted first. Input 5 is granted when input 1's packet releases, with a one-cycle gap. The next contention between 1 and 5 on port 2 goes to 5.
- Input 2 sends header `8'h09` then 3 bytes with EOP → all bytes consumed with `in_ready=1`, no output activity, `drop_cnt=1` (with macro).
- Output 4 drives `out_ready=0` for 5 cycles mid-packet → the owner's `in_ready` is low for those cycles; no byte is lost or duplicated.
- Inputs 0→6 and 7→1 in parallel → both transfer concurrently at full rate.
- `rst` asserted mid-packet on input 0 → all outputs `out_valid=0`. After release, a new header 3 from input 6 is granted normally.
